// File: rtl/pipe_hazard_if.sv
// Hazard-controller bus: per-stage hazard inputs from the pipeline and the
// stage-register control, PC enable and status outputs back to it.
interface pipe_hazard_if #(
    parameter int unsigned CNT_W = 64
);
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic             id_rs1_ren;
    logic             id_rs2_ren;
    logic [4:0]       ex_rd_addr;
    logic             ex_is_load;
    logic             ex_redirect;
    logic             if_ready;
    logic             mem_req;
    logic             mem_ready;
    logic [1:0]       ctrl_if_id;
    logic [1:0]       ctrl_id_ex;
    logic [1:0]       ctrl_ex_mem;
    logic [1:0]       ctrl_mem_wb;
    logic             pc_wen;
    logic             halt_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_ren, id_rs2_ren, ex_rd_addr, ex_is_load,
               ex_redirect, if_ready, mem_req, mem_ready,
        input  ctrl_if_id, ctrl_id_ex, ctrl_ex_mem, ctrl_mem_wb, pc_wen, halt_o, stall_cnt_o
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_ren, id_rs2_ren, ex_rd_addr, ex_is_load,
               ex_redirect, if_ready, mem_req, mem_ready,
        output ctrl_if_id, ctrl_id_ex, ctrl_ex_mem, ctrl_mem_wb, pc_wen, halt_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline controller: prioritised hazard resolution, data-memory
// wait FSM with a halting timeout, and a stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 64
) (
    input logic       clk,
    input logic       rst,
    pipe_hazard_if.slave hz
);
    localparam int unsigned WCW = $clog2(MEM_TIMEOUT);

    localparam logic [1:0] CtrlDefault = 2'b00;
    localparam logic [1:0] CtrlStalled = 2'b01;
    localparam logic [1:0] CtrlBubble  = 2'b10;

    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StWait = 2'b01;
    localparam logic [1:0] StHalt = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       mem_stall;
    logic       load_use;
    logic [1:0] if_id, id_ex, ex_mem, mem_wb;
    logic       pc_wen;

    always_comb begin
        mem_stall = ((state_q == StIdle) && hz.mem_req && !hz.mem_ready) ||
                    ((state_q == StWait) && !hz.mem_ready);
        load_use  = hz.ex_is_load && (hz.ex_rd_addr != 5'd0) &&
                    ((hz.id_rs1_ren && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                     (hz.id_rs2_ren && (hz.id_rs2_addr == hz.ex_rd_addr)));
    end

    // First matching hazard drives every output.
    always_comb begin
        if_id  = CtrlDefault;
        id_ex  = CtrlDefault;
        ex_mem = CtrlDefault;
        mem_wb = CtrlDefault;
        pc_wen = 1'b1;
        if (rst) begin
            if_id  = CtrlBubble;
            id_ex  = CtrlBubble;
            ex_mem = CtrlBubble;
            mem_wb = CtrlBubble;
            pc_wen = 1'b0;
        end else if (state_q == StHalt) begin
            if_id  = CtrlStalled;
            id_ex  = CtrlStalled;
            ex_mem = CtrlStalled;
            mem_wb = CtrlStalled;
            pc_wen = 1'b0;
        end else if (mem_stall) begin
            if_id  = CtrlStalled;
            id_ex  = CtrlStalled;
            ex_mem = CtrlStalled;
            mem_wb = CtrlBubble;
            pc_wen = 1'b0;
        end else if (hz.ex_redirect) begin
            if_id  = CtrlBubble;
            id_ex  = CtrlBubble;
        end else if (load_use) begin
            if_id  = CtrlStalled;
            id_ex  = CtrlBubble;
            pc_wen = 1'b0;
        end else if (!hz.if_ready) begin
            if_id  = CtrlBubble;
            pc_wen = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            StIdle: begin
                if (hz.mem_req && !hz.mem_ready) begin
                    state_d    = StWait;
                    wait_cnt_d = WCW'(1);
                end
            end
            StWait: begin
                if (hz.mem_ready) begin
                    state_d    = StIdle;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCW'(MEM_TIMEOUT - 1)) begin
                    state_d = StHalt;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
        if (!pc_wen) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.ctrl_if_id  = if_id;
    assign hz.ctrl_id_ex  = id_ex;
    assign hz.ctrl_ex_mem = ex_mem;
    assign hz.ctrl_mem_wb = mem_wb;
    assign hz.pc_wen      = pc_wen;
    assign hz.halt_o      = (state_q == StHalt);
    assign hz.stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4): expectations are queued
// when each step is driven and checked mid-cycle against the DUT.
module tb_pipe_hazard_ctrl;
    localparam int unsigned CNT_W = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_if #(.CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct {
        logic [1:0]       if_id;
        logic [1:0]       id_ex;
        logic [1:0]       ex_mem;
        logic [1:0]       mem_wb;
        logic             pc_wen;
        logic             halt;
        logic [CNT_W-1:0] cnt;
        string            tag;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_stall = '0;

    task automatic cmp(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, req);
        end
    endtask

    // Queue the expected outputs for this cycle, check them, then clock.
    task automatic step(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                        input logic [1:0] d, input logic pc, input logic hl, input string tag);
        exp_t e;
        e = '{if_id: a, id_ex: b, ex_mem: c, mem_wb: d, pc_wen: pc, halt: hl,
              cnt: exp_stall, tag: tag};
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        cmp({e.tag, ".if_id"},  CNT_W'(hz.ctrl_if_id),  CNT_W'(e.if_id));
        cmp({e.tag, ".id_ex"},  CNT_W'(hz.ctrl_id_ex),  CNT_W'(e.id_ex));
        cmp({e.tag, ".ex_mem"}, CNT_W'(hz.ctrl_ex_mem), CNT_W'(e.ex_mem));
        cmp({e.tag, ".mem_wb"}, CNT_W'(hz.ctrl_mem_wb), CNT_W'(e.mem_wb));
        cmp({e.tag, ".pc_wen"}, CNT_W'(hz.pc_wen),      CNT_W'(e.pc_wen));
        cmp({e.tag, ".halt"},   CNT_W'(hz.halt_o),      CNT_W'(e.halt));
        cmp({e.tag, ".cnt"},    hz.stall_cnt_o,         e.cnt);
        @(posedge clk);
        if (rst) exp_stall = '0;
        else if (!pc) exp_stall = exp_stall + 1;
        #1;
    endtask

    task automatic quiet();
        hz.id_rs1_addr = 5'd0;
        hz.id_rs2_addr = 5'd0;
        hz.id_rs1_ren  = 1'b0;
        hz.id_rs2_ren  = 1'b0;
        hz.ex_rd_addr  = 5'd0;
        hz.ex_is_load  = 1'b0;
        hz.ex_redirect = 1'b0;
        hz.if_ready    = 1'b1;
        hz.mem_req     = 1'b0;
        hz.mem_ready   = 1'b0;
    endtask

    task automatic load_hit_rs2(input logic [4:0] rd);
        hz.ex_is_load  = 1'b1;
        hz.ex_rd_addr  = rd;
        hz.id_rs2_ren  = 1'b1;
        hz.id_rs2_addr = rd;
    endtask

    initial begin
        quiet();
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, "reset");
        rst = 1'b0;
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, "idle0");
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, "idle1");

        load_hit_rs2(5'd5);
        step(2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, "lu_rs2");
        quiet();
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, "lu_after");
        load_hit_rs2(5'd0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, "lu_x0");
        quiet();
        hz.ex_is_load = 1'b1; hz.ex_rd_addr = 5'd7; hz.id_rs1_ren = 1'b1; hz.id_rs1_addr = 5'd7;
        step(2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, "lu_rs1");
        hz.id_rs1_ren = 1'b0;
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, "lu_noren");
        quiet();

        hz.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) step(2'b01, 2'b01, 2'b01, 2'b10, 1'b0, 1'b0, "mem_wait");
        hz.mem_ready = 1'b1;
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, "mem_done");
        quiet();
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, "mem_cnt");

        hz.mem_req = 1'b1; hz.ex_redirect = 1'b1; load_hit_rs2(5'd9);
        step(2'b01, 2'b01, 2'b01, 2'b10, 1'b0, 1'b0, "prio_mem");
        hz.mem_ready = 1'b1;
        step(2'b10, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, "prio_redir");
        quiet();

        hz.if_ready = 1'b0;
        step(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, "if_wait");
        hz.ex_redirect = 1'b1;
        step(2'b10, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, "redir_ifw");
        hz.ex_redirect = 1'b0; load_hit_rs2(5'd3);
        step(2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, "lu_ifw");
        quiet();

        hz.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) step(2'b01, 2'b01, 2'b01, 2'b10, 1'b0, 1'b0, "to_wait");
        step(2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1, "halt0");
        hz.mem_ready = 1'b1;
        step(2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1, "halt_rdy");
        step(2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1, "halt_rdy2");
        rst = 1'b1;
        step(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1, "halt_rst");
        quiet();
        rst = 1'b0;
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
